spi_regfile_periph: RTL and testbench



---
 rtl/spi_regfile_periph.sv | 178 +++++++++++++++++
 tb/tb_spi_regfile_periph.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_periph.sv
// SPI peripheral register file: write/read-back frames clocked by sclk.
// Frame = rw bit, address, data, all MSB first; read data on cipo.
module spi_regfile_periph #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int NUM_REGS = 5,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       sclk,
  input  logic                       rst_n,
  input  logic                       cs_n,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_valid,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       addr_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CW = $clog2(FRAME_W + 1);
  localparam logic [CW-1:0] CNT_LA = CW'(ADDR_W);
  localparam logic [CW-1:0] CNT_LD = CW'(FRAME_W - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(FRAME_W);
  localparam logic [ADDR_W:0] NREG = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    S_RW,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_e;

  logic              frm_rst_n;
  state_e            st;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              cipo_q, cipo_d;
  logic              oe_q, oe_d;
  logic              wv_q, wv_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              addr_err_q, addr_err_d;

  logic [ADDR_W:0]   addr_shl;
  logic [DATA_W:0]   data_shl;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [DATA_W-1:0] rd_sel;
  logic [DATA_W-1:0] rd_shl;
  logic              addr_ok;

  // Frame state is held clear whenever the chip is deselected.
  assign frm_rst_n = rst_n & ~cs_n;

  always_comb begin
    st = S_DATA;
    unique case (1'b1)
      (cnt_q == '0):                      st = S_RW;
      (cnt_q != '0 && cnt_q <= CNT_LA):   st = S_ADDR;
      (cnt_q > CNT_LA && cnt_q < CNT_DONE): st = S_DATA;
      (cnt_q >= CNT_DONE):                st = S_DONE;
    endcase
  end

  always_comb begin
    addr_shl = {addr_q, copi};
    data_shl = {data_q, copi};
    addr_nxt = addr_shl[ADDR_W-1:0];
    data_nxt = data_shl[DATA_W-1:0];
    rd_shl   = rd_q << 1;
    addr_ok  = {1'b0, addr_q} < NREG;
    rd_sel   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_nxt == ADDR_W'(i)) rd_sel = regs_q[i];
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_d       = rd_q;
    cipo_d     = cipo_q;
    oe_d       = oe_q;
    wv_d       = 1'b0;
    regs_d     = regs_q;
    wr_addr_d  = wr_addr_q;
    addr_err_d = addr_err_q;
    unique case (st)
      S_RW: begin
        rw_d  = copi;
        cnt_d = cnt_q + 1'b1;
      end
      S_ADDR: begin
        addr_d = addr_nxt;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LA && !rw_q) begin
          rd_d   = rd_sel;
          cipo_d = rd_sel[DATA_W-1];
          oe_d   = 1'b1;
        end
      end
      S_DATA: begin
        data_d = data_nxt;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LD) begin
          cipo_d     = 1'b0;
          oe_d       = 1'b0;
          addr_err_d = !addr_ok;
          if (rw_q && addr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (addr_q == ADDR_W'(i)) regs_d[i] = data_nxt;
            end
            wr_addr_d = addr_q;
            wv_d      = 1'b1;
          end
        end else if (!rw_q) begin
          rd_d   = rd_shl;
          cipo_d = rd_shl[DATA_W-1];
        end
      end
      S_DONE: begin
      end
    endcase
  end

  always_ff @(posedge sclk or negedge frm_rst_n) begin
    if (!frm_rst_n) begin
      cnt_q  <= '0;
      rw_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      rd_q   <= '0;
      cipo_q <= 1'b0;
      oe_q   <= 1'b0;
      wv_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rw_q   <= rw_d;
      addr_q <= addr_d;
      data_q <= data_d;
      rd_q   <= rd_d;
      cipo_q <= cipo_d;
      oe_q   <= oe_d;
      wv_q   <= wv_d;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      wr_addr_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      wr_addr_q  <= wr_addr_d;
      addr_err_q <= addr_err_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign cipo     = cipo_q;
  assign cipo_oe  = oe_q;
  assign wr_valid = wv_q;
  assign wr_addr  = wr_addr_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Directed bench for spi_regfile_periph: write, read-back, errors,
// abort, overrun and mid-frame reset.
module tb_spi_regfile_periph;

  logic        sclk = 1'b0;
  logic        rst_n;
  logic        cs_n;
  logic        copi;
  logic        cipo;
  logic        cipo_oe;
  logic [39:0] regs_flat;
  logic        wr_valid;
  logic [6:0]  wr_addr;
  logic        addr_err;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0]  rd;
  int          wv;
  logic        oe_mid;
  logic        oe_end;
  logic [6:0]  wa;
  logic [15:0] w;

  spi_regfile_periph dut (
    .sclk(sclk),
    .rst_n(rst_n),
    .cs_n(cs_n),
    .copi(copi),
    .cipo(cipo),
    .cipo_oe(cipo_oe),
    .regs_flat(regs_flat),
    .wr_valid(wr_valid),
    .wr_addr(wr_addr),
    .addr_err(addr_err)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives n bits MSB first, sampling outputs on each negedge.
  task automatic xfer(input logic [31:0] bits, input int n,
                      output logic [7:0] rdat, output int wvc,
                      output logic oem, output logic oee,
                      output logic [6:0] wadr);
    rdat = '0;
    wvc  = 0;
    oem  = 1'b0;
    wadr = '0;
    @(negedge sclk);
    cs_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      copi = bits[n-1-i];
      @(posedge sclk);
      @(negedge sclk);
      if (wr_valid) begin
        wvc++;
        wadr = wr_addr;
      end
      if (i == 7) oem = cipo_oe;
      if (i >= 7 && i <= 14) rdat = {rdat[6:0], cipo};
    end
    oee  = cipo_oe;
    cs_n = 1'b1;
    copi = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    cs_n  = 1'b1;
    copi  = 1'b0;
    #12;
    chk("rst_regs", 64'(regs_flat), 64'h0);
    chk("rst_cipo", 64'(cipo), 64'h0);
    chk("rst_oe", 64'(cipo_oe), 64'h0);
    chk("rst_wv", 64'(wr_valid), 64'h0);
    chk("rst_aerr", 64'(addr_err), 64'h0);
    chk("rst_waddr", 64'(wr_addr), 64'h0);
    @(negedge sclk);
    rst_n = 1'b1;

    xfer({16'h0, 1'b1, 7'd2, 8'hA5}, 16, rd, wv, oe_mid, oe_end, wa);
    chk("w2_regs", 64'(regs_flat), 64'h00_00_A5_00_00);
    chk("w2_wv", 64'(wv), 64'd1);
    chk("w2_waddr", 64'(wa), 64'd2);
    chk("w2_wv_cs", 64'(wr_valid), 64'h0);
    chk("w2_aerr", 64'(addr_err), 64'h0);

    xfer({16'h0, 1'b1, 7'd4, 8'h3C}, 16, rd, wv, oe_mid, oe_end, wa);
    chk("w4_regs", 64'(regs_flat), 64'h3C_00_A5_00_00);
    chk("w4_waddr", 64'(wa), 64'd4);

    xfer({16'h0, 1'b0, 7'd2, 8'h00}, 16, rd, wv, oe_mid, oe_end, wa);
    chk("r2_data", 64'(rd), 64'hA5);
    chk("r2_oe_mid", 64'(oe_mid), 64'h1);
    chk("r2_oe_end", 64'(oe_end), 64'h0);
    chk("r2_wv", 64'(wv), 64'd0);
    chk("r2_regs", 64'(regs_flat), 64'h3C_00_A5_00_00);

    xfer({16'h0, 1'b1, 7'd5, 8'hFF}, 16, rd, wv, oe_mid, oe_end, wa);
    chk("w5_regs", 64'(regs_flat), 64'h3C_00_A5_00_00);
    chk("w5_wv", 64'(wv), 64'd0);
    chk("w5_aerr", 64'(addr_err), 64'h1);

    w = {1'b1, 7'd1, 8'h77};
    xfer({22'h0, w[15:6]}, 10, rd, wv, oe_mid, oe_end, wa);
    chk("abort_regs", 64'(regs_flat), 64'h3C_00_A5_00_00);
    chk("abort_wv", 64'(wv), 64'd0);
    chk("abort_aerr", 64'(addr_err), 64'h1);

    xfer({16'h0, w}, 16, rd, wv, oe_mid, oe_end, wa);
    chk("w1_regs", 64'(regs_flat), 64'h3C_00_A5_77_00);
    chk("w1_aerr", 64'(addr_err), 64'h0);

    xfer({16'h0, 1'b1, 7'd0, 8'h11}, 16, rd, wv, oe_mid, oe_end, wa);
    chk("w0_regs", 64'(regs_flat), 64'h3C_00_A5_77_11);
    chk("w0_waddr", 64'(wa), 64'd0);

    xfer({16'h0, 1'b0, 7'd6, 8'h00}, 16, rd, wv, oe_mid, oe_end, wa);
    chk("r6_data", 64'(rd), 64'h00);
    chk("r6_aerr", 64'(addr_err), 64'h1);

    xfer({12'h0, 1'b1, 7'd3, 8'h12, 4'hF}, 20, rd, wv, oe_mid, oe_end, wa);
    chk("ovr_regs", 64'(regs_flat), 64'h3C_12_A5_77_11);
    chk("ovr_wv", 64'(wv), 64'd1);
    chk("ovr_waddr", 64'(wa), 64'd3);
    chk("ovr_aerr", 64'(addr_err), 64'h0);

    w  = {1'b1, 7'd4, 8'h55};
    wv = 0;
    @(negedge sclk);
    cs_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      copi = w[15-i];
      @(posedge sclk);
      @(negedge sclk);
    end
    rst_n = 1'b0;
    #1;
    chk("mrst_regs", 64'(regs_flat), 64'h0);
    chk("mrst_waddr", 64'(wr_addr), 64'h0);
    chk("mrst_oe", 64'(cipo_oe), 64'h0);
    @(negedge sclk);
    rst_n = 1'b1;
    for (int i = 12; i < 16; i++) begin
      copi = w[15-i];
      @(posedge sclk);
      @(negedge sclk);
      if (wr_valid) wv++;
    end
    cs_n = 1'b1;
    #1;
    chk("mrst_after", 64'(regs_flat), 64'h0);
    chk("mrst_wv", 64'(wv), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
